// File: rtl/kyber_pkg.sv
// Shared constants and enums for the Kyber polynomial sampler.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;

  // Run mode, sampled on start.
  typedef enum logic [1:0] {
    UNIFORM = 2'd0,
    CBD2    = 2'd1,
    CBD3    = 2'd2,
    RSVD    = 2'd3
  } sampler_mode_t;

  // Sampler run FSM.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sampler_state_t;

endpackage

// File: rtl/kyber_cbd_unit.sv
// Centered binomial sample: popcount of the low ETA bits minus popcount of
// the high ETA bits, negative results folded into [0,Q) by adding Q.
module kyber_cbd_unit
  import kyber_pkg::*;
#(
  parameter int ETA    = 2,
  parameter int COEF_W = 12,
  parameter int Q      = KYBER_Q
) (
  input  logic [2*ETA-1:0] bits,
  output logic [COEF_W-1:0] coef
);

  logic [3:0] pos, neg;

  // Popcount both halves, subtract, wrap negatives into the field.
  always_comb begin
    pos = '0;
    neg = '0;
    for (int i = 0; i < ETA; i++) begin
      pos = pos + 4'(bits[i]);
      neg = neg + 4'(bits[ETA+i]);
    end
    if (pos >= neg) coef = COEF_W'(pos - neg);
    else            coef = COEF_W'(Q) - COEF_W'(neg - pos);
  end

endmodule

// File: rtl/kyber_poly_sampler.sv
// Kyber XOF-to-coefficient sampler: byte buffer, group decoder (uniform
// rejection / CBD eta2 / CBD eta3), 4-entry staging and valid/ready output.
// Optional feature: define KYBER_SAMPLER_REJCNT_EN to add the rej_cnt port,
// a saturating count of rejected uniform candidates for the current run.
module kyber_poly_sampler
  import kyber_pkg::*;
#(
  parameter int DIN_W  = 32,
  parameter int COEF_W = 12,
  parameter int Q      = KYBER_Q,
  parameter int N_COEF = KYBER_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [COEF_W-1:0] coef,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              busy,
  output logic              done
`ifdef KYBER_SAMPLER_REJCNT_EN
  ,
  output logic [8:0]        rej_cnt
`endif
);

  localparam int NB    = DIN_W / 8;
  localparam int BUF_B = NB + 3;
  localparam int BUF_W = 8 * BUF_B;
  localparam int CW    = $clog2(BUF_B + 1);
  localparam int NCW   = $clog2(N_COEF + 1);

  // din_ready while at least one full word of free space remains.
  localparam logic [CW-1:0]  FREE_LIM = CW'(BUF_B - NB);
  localparam logic [CW-1:0]  NB_C     = CW'(NB);
  localparam logic [NCW-1:0] LAST_C   = NCW'(N_COEF - 1);

  sampler_state_t state, state_d;
  sampler_mode_t  mode_q;

  logic [BUF_W-1:0]        buf_q;
  logic [CW-1:0]           buf_cnt;
  logic [3:0][COEF_W-1:0]  stg_q;
  logic [2:0]              stg_cnt;
  logic [NCW-1:0]          coef_cnt;

  logic                    run, start_ok, acc, pop, dec_fire, last_hs;
  logic [CW-1:0]           need, cons;
  logic [3:0][COEF_W-1:0]  dec_ent;
  logic [2:0]              dec_n;

  logic [7:0]              b0, b1, b2;
  logic [23:0]             grp24;
  logic [11:0]             d1, d2;
  logic                    k1, k2;
  logic [COEF_W-1:0]       c2 [2];
  logic [COEF_W-1:0]       c3 [4];

  // ---------------------------------------------------------------------
  // Handshakes and group-decode trigger
  // ---------------------------------------------------------------------
  assign start_ok   = (state == S_IDLE) & start & (sampler_mode_t'(mode) != RSVD);
  assign coef_valid = run & (stg_cnt != 3'd0);
  assign coef       = stg_q[0];
  assign pop        = coef_valid & coef_ready;
  assign last_hs    = pop & (coef_cnt == LAST_C);
  assign din_ready  = run & (buf_cnt <= FREE_LIM);
  assign acc        = din_valid & din_ready;

  // Bytes consumed per group: one for eta2, three otherwise.
  assign need = (mode_q == CBD2) ? CW'(1) : CW'(3);

  // Decode only refills an empty (or emptying) staging, so the new group
  // always lands at the head and ordering is trivially preserved.
  assign dec_fire = run & (buf_cnt >= need) &
                    ((stg_cnt == 3'd0) | ((stg_cnt == 3'd1) & pop));
  assign cons     = dec_fire ? need : '0;

  // ---------------------------------------------------------------------
  // Field extraction and per-lane CBD units
  // ---------------------------------------------------------------------
  assign b0    = buf_q[7:0];
  assign b1    = buf_q[15:8];
  assign b2    = buf_q[23:16];
  assign grp24 = {b2, b1, b0};
  assign d1    = {b1[3:0], b0};
  assign d2    = {b2, b1[7:4]};
  assign k1    = int'(d1) < Q;
  assign k2    = int'(d2) < Q;

  for (genvar g = 0; g < 2; g++) begin : g_cbd2
    kyber_cbd_unit #(.ETA(2), .COEF_W(COEF_W), .Q(Q)) u_cbd (
      .bits (b0[4*g +: 4]),
      .coef (c2[g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_cbd3
    kyber_cbd_unit #(.ETA(3), .COEF_W(COEF_W), .Q(Q)) u_cbd (
      .bits (grp24[6*g +: 6]),
      .coef (c3[g])
    );
  end

  // Build the coefficient group for the current mode, packed from index 0.
  always_comb begin
    dec_ent = '0;
    dec_n   = 3'd0;
    case (mode_q)
      CBD2: begin
        dec_ent[0] = c2[0];
        dec_ent[1] = c2[1];
        dec_n      = 3'd2;
      end
      CBD3: begin
        for (int i = 0; i < 4; i++) dec_ent[i] = c3[i];
        dec_n = 3'd4;
      end
      default: begin
        // Rejected candidates leave no hole; d1 stays ahead of d2.
        if (k1) begin
          dec_ent[0] = COEF_W'(d1);
          dec_ent[1] = COEF_W'(d2);
          dec_n      = k2 ? 3'd2 : 3'd1;
        end else begin
          dec_ent[0] = COEF_W'(d2);
          dec_n      = k2 ? 3'd1 : 3'd0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Byte buffer: consume from the bottom, append the new word right after
  // the surviving bytes. Unused upper bytes are kept zero so the append
  // can be a plain OR.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      buf_cnt <= '0;
    end else if (state == S_DONE) begin
      buf_q   <= '0;
      buf_cnt <= '0;
    end else begin
      buf_q   <= (buf_q >> (8 * cons)) |
                 (acc ? (BUF_W'(din) << (8 * (buf_cnt - cons))) : '0);
      buf_cnt <= buf_cnt - cons + (acc ? NB_C : '0);
    end
  end

  // Staging register: load a whole group, or shift out the head on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_q   <= '0;
      stg_cnt <= 3'd0;
    end else if (state == S_DONE) begin
      stg_q   <= '0;
      stg_cnt <= 3'd0;
    end else if (dec_fire) begin
      stg_q   <= dec_ent;
      stg_cnt <= dec_n;
    end else if (pop) begin
      stg_q   <= {{COEF_W{1'b0}}, stg_q[3:1]};
      stg_cnt <= stg_cnt - 3'd1;
    end
  end

  // Output handshake counter; reaching N_COEF ends the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  coef_cnt <= '0;
    else if (state == S_DONE) coef_cnt <= '0;
    else if (pop)             coef_cnt <= coef_cnt + NCW'(1);
  end

  // Mode is latched only when a run actually starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           mode_q <= UNIFORM;
    else if (start_ok) mode_q <= sampler_mode_t'(mode);
  end

  // ---------------------------------------------------------------------
  // Run FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next state and status outputs.
  always_comb begin
    state_d = state;
    run     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: if (start_ok) state_d = S_RUN;
      S_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
        if (last_hs) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef KYBER_SAMPLER_REJCNT_EN
  logic [8:0] rej_q;
  logic [1:0] dec_rej;
  logic [9:0] rej_sum;

  assign dec_rej = (mode_q == UNIFORM) ? ({1'b0, ~k1} + {1'b0, ~k2}) : 2'd0;
  assign rej_sum = {1'b0, rej_q} + {8'd0, dec_rej};
  assign rej_cnt = rej_q;

  // Saturating rejection count, cleared when a new run starts and held after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rej_q <= '0;
    else if (start_ok) rej_q <= '0;
    else if (dec_fire) rej_q <= rej_sum[9] ? 9'd511 : rej_sum[8:0];
  end
`endif

endmodule

// File: tb/tb_kyber_poly_sampler.sv
// Scoreboard bench for kyber_poly_sampler: a byte-queue reference model
// pushes expected coefficients, a negedge monitor pops and compares.
module tb_kyber_poly_sampler;

  localparam int Q = 3329;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [11:0] coef;
  logic        coef_valid;
  logic        coef_ready = 1'b1;
  logic        busy, done;
`ifdef KYBER_SAMPLER_REJCNT_EN
  logic [8:0]  rej_cnt;
`endif

  always #5 clk = ~clk;

  kyber_poly_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .coef       (coef),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done)
`ifdef KYBER_SAMPLER_REJCNT_EN
    ,
    .rej_cnt    (rej_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int mq[$];
  int hs_cnt = 0;
  int done_cnt = 0;
  int model_rej = 0;
  int prev_coef = 0;
  bit exp_done = 0;
  bit prev_stall = 0;
  bit abort = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Reference CBD: popcount difference, negatives lifted by Q.
  function automatic int cbd(input int field, input int eta);
    int a, b, r;
    a = $countones(field & ((1 << eta) - 1));
    b = $countones(field >> eta);
    r = a - b;
    return (r < 0) ? r + Q : r;
  endfunction

  // Reference model: append word bytes, consume whole groups.
  task automatic model_push(input logic [31:0] w, input int m);
    int x, y, z, v, c1, c2;
    for (int i = 0; i < 4; i++) mq.push_back(int'((w >> (8 * i)) & 32'hFF));
    while (1) begin
      if (m == 1) begin
        if (mq.size() < 1) break;
        x = mq.pop_front();
        exp_q.push_back(cbd(x & 15, 2));
        exp_q.push_back(cbd(x >> 4, 2));
      end else begin
        if (mq.size() < 3) break;
        x = mq.pop_front();
        y = mq.pop_front();
        z = mq.pop_front();
        v = x + 256 * y + 65536 * z;
        if (m == 2) begin
          for (int i = 0; i < 4; i++) exp_q.push_back(cbd((v >> (6 * i)) & 63, 3));
        end else begin
          c1 = v % 4096;
          c2 = v / 4096;
          if (c1 < Q) exp_q.push_back(c1); else model_rej++;
          if (c2 < Q) exp_q.push_back(c2); else model_rej++;
        end
      end
    end
  endtask

  // Monitor: scoreboard pops, hold-while-stalled, done pulse timing.
  always @(negedge clk) begin
    int e;
    if (rst) begin
      prev_stall = 0;
      exp_done   = 0;
    end else begin
      if (exp_done) begin
        chk(done == 1'b1, "done_pulse", done, 1);
        chk(coef_valid == 1'b0, "valid_in_done", coef_valid, 0);
        exp_done = 0;
      end else if (done) begin
        chk(0, "spurious_done", 1, 0);
      end
      if (done) done_cnt++;
      if (prev_stall)
        chk(coef_valid && (int'(coef) == prev_coef), "coef_hold", coef, prev_coef);
      prev_stall = coef_valid && !coef_ready;
      prev_coef  = int'(coef);
      if (coef_valid && coef_ready) begin
        chk(int'(coef) < Q, "coef_range", coef, Q - 1);
        if (exp_q.size() == 0) chk(0, "unexpected_coef", coef, -1);
        else begin
          e = exp_q.pop_front();
          chk(int'(coef) == e, "coef", coef, e);
        end
        hs_cnt++;
        if (hs_cnt == N) exp_done = 1;
      end
    end
  end

  task automatic start_run(input int m);
    exp_q.delete();
    mq.delete();
    hs_cnt = 0;
    model_rej = 0;
    abort = 0;
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'(m);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int m, input bit use_model);
    din = w;
    din_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy || hs_cnt >= N || rst) begin
        din_valid = 1'b0;
        return;
      end
      if (din_ready) begin
        if (use_model) model_push(w, m);
        @(posedge clk); #1;
        din_valid = 1'b0;
        return;
      end
    end
    chk(0, "din_accept_timeout", 0, 1);
    abort = 1;
    din_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    chk(0, nm, exp_q.size(), 0);
  endtask

  task automatic abort_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(coef_valid == 1'b0, "rst_coef_valid", coef_valid, 0);
    chk(din_ready == 1'b0, "rst_din_ready", din_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic ready_ctl(input bit rready, input bit stall);
    bit saw_low;
    int h0;
    saw_low = 0;
    if (stall) begin
      while (hs_cnt < 60 && !abort && busy) @(posedge clk);
      #1;
      coef_ready = 1'b0;
      h0 = hs_cnt;
      repeat (10) begin
        @(negedge clk);
        if (!din_ready) saw_low = 1;
      end
      chk(saw_low, "din_ready_drop", saw_low, 1);
      chk(hs_cnt == h0, "no_hs_in_stall", hs_cnt, h0);
      @(posedge clk); #1;
      coef_ready = 1'b1;
    end
    if (rready) begin
      while (hs_cnt < N && !abort && busy) begin
        @(posedge clk); #1;
        coef_ready = ($urandom_range(3) != 0);
      end
      coef_ready = 1'b1;
    end
  endtask

  task automatic full_run(input int m, input bit rready, input bit stall);
    int d0;
    start_run(m);
    d0 = done_cnt;
    fork
      begin
        while (hs_cnt < N && !abort) send_word($urandom, m, 1);
      end
      begin
        ready_ctl(rready, stall);
      end
    join
    coef_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    din_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk(din_ready == 1'b0, "din_ready_after", din_ready, 0);
    din_valid = 1'b0;
    chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
    chk(hs_cnt == N, "handshakes", hs_cnt, N);
    chk(busy == 1'b0, "busy_after", busy, 0);
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(done == 1'b0, "reset_done", done, 0);
    chk(coef_valid == 1'b0, "reset_coef_valid", coef_valid, 0);
    chk(din_ready == 1'b0, "reset_din_ready", din_ready, 0);
    chk(coef == 12'd0, "reset_coef", coef, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Uniform, single word 00030201.
    start_run(0);
    exp_q.push_back(513);
    exp_q.push_back(48);
    send_word(32'h00030201, 0, 0);
    wait_drain("drain_uniform_a");
`ifdef KYBER_SAMPLER_REJCNT_EN
    chk(rej_cnt == 9'd0, "rej_cnt_a", rej_cnt, 0);
`endif
    abort_rst();

    // Uniform boundary: 3329 rejected, 3328 kept, FF FF FF fully rejected.
    start_run(0);
    exp_q.push_back(0);
    exp_q.push_back(3328);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    send_word(32'h00000D01, 0, 0);
    send_word(32'hFFFF000D, 0, 0);
    send_word(32'h000000FF, 0, 0);
    wait_drain("drain_uniform_b");
    repeat (3) @(negedge clk);
    chk(coef_valid == 1'b0, "no_extra_coef", coef_valid, 0);
`ifdef KYBER_SAMPLER_REJCNT_EN
    chk(rej_cnt == 9'd3, "rej_cnt_b", rej_cnt, 3);
`endif
    abort_rst();

    // eta2: bytes 0F 03 0C 00.
    start_run(1);
    foreach (exp_q[i]) exp_q.delete();
    exp_q.push_back(0);    exp_q.push_back(0);
    exp_q.push_back(2);    exp_q.push_back(0);
    exp_q.push_back(3327); exp_q.push_back(0);
    exp_q.push_back(0);    exp_q.push_back(0);
    send_word(32'h000C030F, 1, 0);
    wait_drain("drain_eta2");
    abort_rst();

    // Full uniform run with a 10-cycle sink stall mid-run.
    full_run(0, 0, 1);

    // eta3 run aborted by reset, then a clean eta3 run.
    start_run(2);
    send_word($urandom, 2, 1);
    send_word($urandom, 2, 1);
    send_word($urandom, 2, 1);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    abort_rst();
    repeat (2) @(negedge clk);
    chk(done_cnt == d0, "no_done_on_abort", done_cnt - d0, 0);
    full_run(2, 1, 0);

    // Full eta2 and uniform runs with random backpressure.
    full_run(1, 1, 0);
    full_run(0, 1, 0);

    // Reserved mode: never starts.
    d0 = done_cnt;
    start_run(3);
    din_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk(busy == 1'b0, "rsvd_busy", busy, 0);
    chk(din_ready == 1'b0, "rsvd_din_ready", din_ready, 0);
    din_valid = 1'b0;
    chk(done_cnt == d0, "rsvd_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
